// File: rtl/edge_detector_multi.sv
// ---------------------------------------------------------------------------
// edge_detector_multi
//
// Multi-channel stability/edge qualifier. Each channel waits for a trigger,
// then requires its line to sit at a target level for a programmable number
// of clocks before pulsing detect. The channel is placed between the bus
// input synchronisers and the controller FSMs. By convention ch0 is SCL and
// ch1 is SDA.
//
// Parameters
//   NUM_CH            number of independent channels (1..16)
//   CNTR_W            width of the stability counter and delay_count_i
//   RESTART_ON_GLITCH 0: counter stalls while the line is off target
//                     1: counter clears and glitch_o pulses on off-target
//
// Ports
//   clk_i          clock
//   rst_ni         asynchronous active-low reset
//   trigger_i      per-channel start / restart request
//   line_i         synchronised line values
//   mode_i         per-channel mode, bits [2c+1:2c]
//                  00 off, 01 rising (target 1), 10 falling (target 0),
//                  11 any (target = line value sampled with the trigger)
//   delay_count_i  required stable time in clocks, shared by all channels
//   detect_o       one-cycle qualified-edge pulse
//   busy_o         channel is qualifying (CHECK state)
//   glitch_o       one-cycle pulse per off-target sample while qualifying
//                  (only when RESTART_ON_GLITCH=1, otherwise always 0)
//
// Optional feature (define EDGE_DETECTOR_MULTI_GLITCH_STATS_EN)
//   glitch_clr_i   synchronous clear of all glitch counters
//   glitch_cnt_o   8-bit saturating off-target sample count per channel,
//                  channel c at bits [8c+7:8c]
// ---------------------------------------------------------------------------
module edge_detector_multi #(
  parameter int unsigned NUM_CH            = 2,
  parameter int unsigned CNTR_W            = 20,
  parameter bit          RESTART_ON_GLITCH = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NUM_CH-1:0]     trigger_i,
  input  logic [NUM_CH-1:0]     line_i,
  input  logic [2*NUM_CH-1:0]   mode_i,
  input  logic [CNTR_W-1:0]     delay_count_i,
`ifdef EDGE_DETECTOR_MULTI_GLITCH_STATS_EN
  input  logic                  glitch_clr_i,
  output logic [8*NUM_CH-1:0]   glitch_cnt_o,
`endif
  output logic [NUM_CH-1:0]     detect_o,
  output logic [NUM_CH-1:0]     busy_o,
  output logic [NUM_CH-1:0]     glitch_o
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CHECK = 1'b1
  } state_e;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_ANY  = 2'b11;

  // A zero delay never enters CHECK: the trigger is passed straight through.
  logic zero_delay;
  assign zero_delay = (delay_count_i == '0);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_e            state_q, state_d;
    logic [CNTR_W-1:0] count_q, count_d;
    logic [CNTR_W-1:0] delay_q, delay_d;
    logic              target_q, target_d;
    logic              detect_q, detect_d;
    logic              glitch_q, glitch_d;
    logic [1:0]        mode;
    logic              trig_ok;
    logic              off_target;

    assign mode    = mode_i[2*c +: 2];
    assign trig_ok = trigger_i[c] && (mode != MODE_OFF);

    // A retrigger is a restart, not a glitch, so it never counts as an
    // off-target sample even if the line happens to be off target.
    assign off_target = (state_q == ST_CHECK) && !trig_ok &&
                        (line_i[c] != target_q);

    // NOTE: every signal written here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      delay_d  = delay_q;
      target_d = target_q;
      detect_d = 1'b0;
      glitch_d = RESTART_ON_GLITCH && off_target;

      if (trig_ok) begin
        // Trigger has priority over completion: a trigger on the completing
        // edge restarts the check and suppresses that detect pulse.
        if (zero_delay) begin
          // Bypass pulse covers this request; abandon any running check.
          state_d = ST_IDLE;
        end else begin
          state_d  = ST_CHECK;
          count_d  = '0;
          delay_d  = delay_count_i;
          // The mode only matters for choosing the target, so the target
          // itself is what gets latched.
          target_d = (mode == MODE_ANY) ? line_i[c] : (mode == MODE_RISE);
        end
      end else if (state_q == ST_CHECK) begin
        if (line_i[c] == target_q) begin
          if (count_q >= delay_q) begin
            detect_d = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            // count_q < delay_q here, so the increment can never wrap.
            count_d = count_q + CNTR_W'(1);
          end
        end else if (RESTART_ON_GLITCH) begin
          count_d = '0;
        end
      end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q  <= ST_IDLE;
        count_q  <= '0;
        delay_q  <= '0;
        target_q <= 1'b0;
        detect_q <= 1'b0;
        glitch_q <= 1'b0;
      end else begin
        state_q  <= state_d;
        count_q  <= count_d;
        delay_q  <= delay_d;
        target_q <= target_d;
        detect_q <= detect_d;
        glitch_q <= glitch_d;
      end
    end

    assign detect_o[c] = detect_q || (trig_ok && zero_delay);
    assign busy_o[c]   = (state_q == ST_CHECK);
    assign glitch_o[c] = glitch_q;

`ifdef EDGE_DETECTOR_MULTI_GLITCH_STATS_EN
    logic [7:0] gcnt_q;

    // Clear wins over a same-cycle increment; the count sticks at 255.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        gcnt_q <= '0;
      end else if (glitch_clr_i) begin
        gcnt_q <= '0;
      end else if (off_target && (gcnt_q != 8'hFF)) begin
        gcnt_q <= gcnt_q + 8'd1;
      end
    end

    assign glitch_cnt_o[8*c +: 8] = gcnt_q;
`endif
  end

endmodule

// File: tb/tb_edge_detector_multi.sv
// ---------------------------------------------------------------------------
// tb_edge_detector_multi
//
// Directed bench for edge_detector_multi. Three instances share one clock
// and reset: dut (RESTART_ON_GLITCH=0), dut_r (RESTART_ON_GLITCH=1) driven by
// identical inputs, and dut_w (one channel, 3-bit counter) for the
// full-scale delay case. Inputs change 1 time unit after a rising edge and
// outputs are sampled there too; "edge T+k" is the k-th rising edge after
// the one that sampled the trigger.
// ---------------------------------------------------------------------------
module tb_edge_detector_multi;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [1:0]  trigger_i;
  logic [1:0]  line_i;
  logic [3:0]  mode_i;
  logic [19:0] delay_count_i;
  logic [1:0]  detect_o, busy_o, glitch_o;
  logic [1:0]  detect_r, busy_r, glitch_r;

  logic        w_trig, w_line;
  logic [1:0]  w_mode;
  logic [2:0]  w_delay;
  logic        w_det, w_busy, w_glitch;

`ifdef EDGE_DETECTOR_MULTI_GLITCH_STATS_EN
  logic        glitch_clr_i;
  logic [15:0] glitch_cnt_o, glitch_cnt_r;
  logic [7:0]  w_gcnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  edge_detector_multi #(.NUM_CH(2), .CNTR_W(20), .RESTART_ON_GLITCH(1'b0)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .trigger_i(trigger_i), .line_i(line_i),
    .mode_i(mode_i), .delay_count_i(delay_count_i),
`ifdef EDGE_DETECTOR_MULTI_GLITCH_STATS_EN
    .glitch_clr_i(glitch_clr_i), .glitch_cnt_o(glitch_cnt_o),
`endif
    .detect_o(detect_o), .busy_o(busy_o), .glitch_o(glitch_o)
  );

  edge_detector_multi #(.NUM_CH(2), .CNTR_W(20), .RESTART_ON_GLITCH(1'b1)) dut_r (
    .clk_i(clk_i), .rst_ni(rst_ni), .trigger_i(trigger_i), .line_i(line_i),
    .mode_i(mode_i), .delay_count_i(delay_count_i),
`ifdef EDGE_DETECTOR_MULTI_GLITCH_STATS_EN
    .glitch_clr_i(glitch_clr_i), .glitch_cnt_o(glitch_cnt_r),
`endif
    .detect_o(detect_r), .busy_o(busy_r), .glitch_o(glitch_r)
  );

  edge_detector_multi #(.NUM_CH(1), .CNTR_W(3), .RESTART_ON_GLITCH(1'b0)) dut_w (
    .clk_i(clk_i), .rst_ni(rst_ni), .trigger_i(w_trig), .line_i(w_line),
    .mode_i(w_mode), .delay_count_i(w_delay),
`ifdef EDGE_DETECTOR_MULTI_GLITCH_STATS_EN
    .glitch_clr_i(glitch_clr_i), .glitch_cnt_o(w_gcnt),
`endif
    .detect_o(w_det), .busy_o(w_busy), .glitch_o(w_glitch)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni        = 1'b0;
    trigger_i     = '0;
    line_i        = '0;
    mode_i        = '0;
    delay_count_i = '0;
    w_trig        = 1'b0;
    w_line        = 1'b0;
    w_mode        = '0;
    w_delay       = '0;
`ifdef EDGE_DETECTOR_MULTI_GLITCH_STATS_EN
    glitch_clr_i  = 1'b0;
`endif
    step();
    step();
    rst_ni = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_ni        = 1'b0;
    trigger_i     = '0;
    line_i        = 2'b11;
    mode_i        = 4'b0101;
    delay_count_i = 20'd4;
    w_trig        = 1'b0;
    w_line        = 1'b1;
    w_mode        = 2'b01;
    w_delay       = 3'd2;
`ifdef EDGE_DETECTOR_MULTI_GLITCH_STATS_EN
    glitch_clr_i  = 1'b0;
`endif
    #3;
    checks++;
    if ({detect_o, busy_o, glitch_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 000000", {detect_o, busy_o, glitch_o});
    end
    checks++;
    if ({detect_r, busy_r, glitch_r, w_det, w_busy, w_glitch} !== 9'b0) begin
      errors++;
      $display("FAIL reset_outputs_other: got %b expected 0", {detect_r, busy_r, glitch_r, w_det, w_busy, w_glitch});
    end
`ifdef EDGE_DETECTOR_MULTI_GLITCH_STATS_EN
    checks++;
    if ({glitch_cnt_o, glitch_cnt_r, w_gcnt} !== 40'b0) begin
      errors++;
      $display("FAIL reset_glitch_cnt: got %h expected 0", {glitch_cnt_o, glitch_cnt_r, w_gcnt});
    end
`endif
    step();
    rst_ni = 1'b1;
    step();
    checks++;
    if ({detect_o, busy_o, detect_r, busy_r} !== 8'b0) begin
      errors++;
      $display("FAIL reset_release_idle: got %b expected 0", {detect_o, busy_o, detect_r, busy_r});
    end
  endtask

  task automatic test_basic();
    logic [1:0] exp_det, exp_busy;
    do_reset();
    delay_count_i = 20'd4;
    mode_i        = 4'b0101;
    line_i        = 2'b01;
    trigger_i     = 2'b01;
    step();
    trigger_i = 2'b00;
    for (int k = 0; k <= 7; k++) begin
      if (k > 0) step();
      exp_det  = (k == 5) ? 2'b01 : 2'b00;
      exp_busy = (k < 5)  ? 2'b01 : 2'b00;
      checks++;
      if (detect_o !== exp_det) begin
        errors++;
        $display("FAIL basic_detect T+%0d: got %b expected %b", k, detect_o, exp_det);
      end
      checks++;
      if (busy_o !== exp_busy) begin
        errors++;
        $display("FAIL basic_busy T+%0d: got %b expected %b", k, busy_o, exp_busy);
      end
    end
  endtask

  task automatic test_glitch();
    logic [1:0] exp_det, exp_busy, exp_det_r, exp_busy_r, exp_gl_r;
    do_reset();
    delay_count_i = 20'd4;
    mode_i        = 4'b0010;
    line_i        = 2'b00;
    trigger_i     = 2'b01;
    step();
    trigger_i = 2'b00;
    for (int k = 0; k <= 9; k++) begin
      if (k > 0) step();
      exp_det    = (k == 6) ? 2'b01 : 2'b00;
      exp_busy   = (k < 6)  ? 2'b01 : 2'b00;
      exp_det_r  = (k == 8) ? 2'b01 : 2'b00;
      exp_busy_r = (k < 8)  ? 2'b01 : 2'b00;
      exp_gl_r   = (k == 3) ? 2'b01 : 2'b00;
      checks++;
      if ({detect_o, busy_o, glitch_o} !== {exp_det, exp_busy, 2'b00}) begin
        errors++;
        $display("FAIL glitch_stall T+%0d: got det/busy/gl %b expected %b", k,
                 {detect_o, busy_o, glitch_o}, {exp_det, exp_busy, 2'b00});
      end
      checks++;
      if ({detect_r, busy_r, glitch_r} !== {exp_det_r, exp_busy_r, exp_gl_r}) begin
        errors++;
        $display("FAIL glitch_restart T+%0d: got det/busy/gl %b expected %b", k,
                 {detect_r, busy_r, glitch_r}, {exp_det_r, exp_busy_r, exp_gl_r});
      end
      if (k == 2) line_i = 2'b01;
      if (k == 3) line_i = 2'b00;
    end
  endtask

  task automatic test_any_mode();
    logic [1:0] exp_det;
    for (int lv = 0; lv < 2; lv++) begin
      do_reset();
      delay_count_i = 20'd3;
      mode_i        = 4'b0011;
      line_i        = {1'b0, lv[0]};
      trigger_i     = 2'b01;
      step();
      trigger_i = 2'b00;
      for (int k = 0; k <= 5; k++) begin
        if (k > 0) step();
        exp_det = (k == 4) ? 2'b01 : 2'b00;
        checks++;
        if ({detect_o, detect_r} !== {exp_det, exp_det}) begin
          errors++;
          $display("FAIL any_mode line=%0d T+%0d: got %b expected %b", lv, k,
                   {detect_o, detect_r}, {exp_det, exp_det});
        end
      end
    end
  endtask

  task automatic test_bypass();
    do_reset();
    delay_count_i = 20'd0;
    mode_i        = 4'b0100;
    trigger_i     = 2'b10;
    #1;
    checks++;
    if ({detect_o, busy_o} !== 4'b1000) begin
      errors++;
      $display("FAIL bypass_same_cycle: got det/busy %b expected 1000", {detect_o, busy_o});
    end
    step();
    checks++;
    if ({busy_o, busy_r} !== 4'b0000) begin
      errors++;
      $display("FAIL bypass_no_busy: got %b expected 0000", {busy_o, busy_r});
    end
    trigger_i = 2'b00;
    #1;
    checks++;
    if (detect_o !== 2'b00) begin
      errors++;
      $display("FAIL bypass_release: got %b expected 00", detect_o);
    end
    mode_i    = 4'b0000;
    trigger_i = 2'b10;
    #1;
    checks++;
    if (detect_o !== 2'b00) begin
      errors++;
      $display("FAIL bypass_mode_off: got %b expected 00", detect_o);
    end
    step();
    trigger_i = 2'b00;
    checks++;
    if ({detect_o, busy_o} !== 4'b0000) begin
      errors++;
      $display("FAIL bypass_mode_off_idle: got %b expected 0000", {detect_o, busy_o});
    end
  endtask

  task automatic test_retrigger();
    logic [1:0] exp_det, exp_busy;
    do_reset();
    delay_count_i = 20'd6;
    mode_i        = 4'b0001;
    line_i        = 2'b01;
    trigger_i     = 2'b01;
    step();
    trigger_i = 2'b00;
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) step();
      exp_det  = (k == 5) ? 2'b01 : 2'b00;
      exp_busy = (k < 5)  ? 2'b01 : 2'b00;
      checks++;
      if ({detect_o, busy_o} !== {exp_det, exp_busy}) begin
        errors++;
        $display("FAIL retrigger T+%0d: got det/busy %b expected %b", k,
                 {detect_o, busy_o}, {exp_det, exp_busy});
      end
      if (k == 1) delay_count_i = 20'd1;
      if (k == 2) trigger_i = 2'b01;
      if (k == 3) trigger_i = 2'b00;
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_det, exp_busy;
    do_reset();
    delay_count_i = 20'd2;
    mode_i        = 4'b0001;
    line_i        = 2'b01;
    trigger_i     = 2'b01;
    step();
    trigger_i = 2'b00;
    for (int k = 0; k <= 7; k++) begin
      if (k > 0) step();
      exp_det  = (k == 6) ? 2'b01 : 2'b00;
      exp_busy = (k < 6)  ? 2'b01 : 2'b00;
      checks++;
      if ({detect_o, busy_o} !== {exp_det, exp_busy}) begin
        errors++;
        $display("FAIL back_to_back T+%0d: got det/busy %b expected %b", k,
                 {detect_o, busy_o}, {exp_det, exp_busy});
      end
      if (k == 2) trigger_i = 2'b01;
      if (k == 3) trigger_i = 2'b00;
    end
  endtask

  task automatic test_midcheck_reset();
    logic [1:0] exp_busy;
    do_reset();
    delay_count_i = 20'd4;
    mode_i        = 4'b0101;
    line_i        = 2'b01;
    trigger_i     = 2'b01;
    step();
    trigger_i = 2'b00;
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) step();
      exp_busy = (k < 3) ? 2'b01 : 2'b00;
      checks++;
      if ({detect_o, busy_o, detect_r, busy_r} !== {2'b00, exp_busy, 2'b00, exp_busy}) begin
        errors++;
        $display("FAIL midcheck_reset T+%0d: got %b expected %b", k,
                 {detect_o, busy_o, detect_r, busy_r}, {2'b00, exp_busy, 2'b00, exp_busy});
      end
      if (k == 2) begin
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({detect_o, busy_o, glitch_o, detect_r, busy_r, glitch_r} !== 12'b0) begin
          errors++;
          $display("FAIL midcheck_reset_immediate: got %b expected 0",
                   {detect_o, busy_o, glitch_o, detect_r, busy_r, glitch_r});
        end
      end
      if (k == 4) rst_ni = 1'b1;
    end
  endtask

  task automatic test_full_scale_delay();
    logic exp_det, exp_busy;
    do_reset();
    w_delay = 3'd7;
    w_mode  = 2'b01;
    w_line  = 1'b1;
    w_trig  = 1'b1;
    step();
    w_trig = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) step();
      exp_det  = (k == 8);
      exp_busy = (k < 8);
      checks++;
      if ({w_det, w_busy} !== {exp_det, exp_busy}) begin
        errors++;
        $display("FAIL full_scale_delay T+%0d: got det/busy %b expected %b", k,
                 {w_det, w_busy}, {exp_det, exp_busy});
      end
    end
  endtask

`ifdef EDGE_DETECTOR_MULTI_GLITCH_STATS_EN
  task automatic test_glitch_stats();
    do_reset();
    delay_count_i = 20'd1000;
    mode_i        = 4'b0001;
    line_i        = 2'b00;
    trigger_i     = 2'b01;
    step();
    trigger_i = 2'b00;
    for (int k = 1; k <= 300; k++) begin
      step();
      if (k == 10) begin
        checks++;
        if ({glitch_cnt_o, glitch_cnt_r} !== {8'd0, 8'd10, 8'd0, 8'd10}) begin
          errors++;
          $display("FAIL glitch_cnt_10: got %h expected 000a000a", {glitch_cnt_o, glitch_cnt_r});
        end
      end
    end
    checks++;
    if ({glitch_cnt_o, glitch_cnt_r} !== {8'd0, 8'd255, 8'd0, 8'd255}) begin
      errors++;
      $display("FAIL glitch_cnt_saturate: got %h expected 00ff00ff", {glitch_cnt_o, glitch_cnt_r});
    end
    glitch_clr_i = 1'b1;
    step();
    glitch_clr_i = 1'b0;
    checks++;
    if ({glitch_cnt_o, glitch_cnt_r} !== 32'b0) begin
      errors++;
      $display("FAIL glitch_cnt_clear: got %h expected 0", {glitch_cnt_o, glitch_cnt_r});
    end
    step();
    checks++;
    if ({glitch_cnt_o, glitch_cnt_r} !== {8'd0, 8'd1, 8'd0, 8'd1}) begin
      errors++;
      $display("FAIL glitch_cnt_after_clear: got %h expected 00010001", {glitch_cnt_o, glitch_cnt_r});
    end
    do_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_any_mode();
    test_bypass();
    test_retrigger();
    test_back_to_back();
    test_midcheck_reset();
    test_full_scale_delay();
`ifdef EDGE_DETECTOR_MULTI_GLITCH_STATS_EN
    test_glitch_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
